mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory stage of the five-stage pipeline, including the MEM/WB pipeline latch. It consumes the EX/MEM latch outputs and issues data-cache requests. It stalls the upstream pipeline until the cache returns `dhit`, resolves conditional branches, and selects the writeback value. It then registers the result for the writeback stage.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` = 32 bits, `regbits_t` = 5 bits).
- `CLK`  in  1  pipeline clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `em_valid`  in  1  EX/MEM holds a real instruction (0 = bubble).
- `em_dREN`, `em_dWEN`  in  1 each  load / store.
- `em_bEQ`, `em_bNE`, `em_jAL`, `em_lUI`, `em_regWEN`  in  1 each  control bits from EX/MEM.
- `em_zero`  in  1  ALU zero flag.
- `em_pcplusfour`, `em_rdat2`, `em_branch_addr`, `em_alu_out`  in  32 each  EX/MEM data.
- `em_dest_reg`  in  5  destination register.
- `em_imm16`  in  16  LUI immediate.
- `dhit`  in  1  cache completed the current request this cycle.
- `dmemload`  in  32  load data, valid when `dhit`.
- `dmemREN`, `dmemWEN`  out  1 each  cache read / write request.
- `dmemaddr`, `dmemstore`  out  32 each  request address / store data.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `branch_taken`  out  1  redirect PC and flush younger stages.
- `branch_target`  out  32  redirect address.
- `wb_valid`, `wb_regWEN`  out  1 each  registered MEM/WB valid / register-write enable.
- `wb_dest_reg`  out  5  registered destination register.
- `wb_wdat`  out  32  registered writeback data.
- `stall_count`  out  32  registered count of cycles with `mem_stall` high.

## Operation
- `memop = em_valid & (em_dREN | em_dWEN)`. `em_dREN` and `em_dWEN` are never both high.
- Request outputs (combinational):
  - `dmemREN = memop & em_dREN & (state != DONE)`
  - `dmemWEN = memop & em_dWEN & (state != DONE)`
  - `dmemaddr = em_alu_out`
  - `dmemstore = em_rdat2`
- `mem_stall = memop & ~dhit & (state != DONE)`.
- FSM states are IDLE, ACCESS and DONE.
  - From IDLE or ACCESS: `memop & dhit` goes to IDLE and the result latches. `memop & ~dhit` goes to ACCESS.
  - DONE is reserved; it is never entered and returns to IDLE. It must not be reachable.
  - ACCESS holds the request stable until `dhit`.
  - `memop` falling in ACCESS (upstream flush) returns to IDLE and drops the request.
- Branch resolution (combinational):
  - `branch_taken = em_valid & ((em_bEQ & em_zero) | (em_bNE & ~em_zero))`
  - `branch_target = em_branch_addr`
  - A branch carries no memory operation, so it never coincides with `mem_stall`.
- Writeback select, in priority order:
  1. `em_jAL` → `em_pcplusfour`
  2. `em_lUI` → `{em_imm16, 16'h0}`
  3. `em_dREN` → `dmemload`
  4. otherwise → `em_alu_out`
- Destination register: forced to 5'd31 when `em_jAL`, otherwise `em_dest_reg`.
- `regWEN` written into the latch is `em_valid & em_regWEN & ~em_dWEN`.
- MEM/WB latch on each rising edge:
  - `mem_stall` low: capture the select, `wb_valid <= em_valid`.
  - `mem_stall` high: insert a bubble. `wb_valid <= 0` and `wb_regWEN <= 0`; the data fields hold their old values.
- `stall_count` increments by 1 on every edge where `mem_stall` is high. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (`nRST` low, asynchronous): state=IDLE and `stall_count`=0. All `wb_*` are 0, including `wb_wdat`=0 and `wb_dest_reg`=0.
- Combinational outputs during reset follow their equations, except the request outputs, which are forced to 0 while `nRST` is low.
- Reset during ACCESS abandons the request immediately. No store is reissued after reset.
- Hit in the first cycle: `mem_stall` stays low and the result appears on `wb_*` the next cycle (1-cycle latency).
- Miss with `dhit` arriving after N cycles: `mem_stall` is high for N cycles and low in the `dhit` cycle. The latch captures at the end of the `dhit` cycle. `wb_*` show N bubbles, then the instruction.
- Each store produces exactly one `dmemWEN` window ending in exactly one `dhit`.
- Non-memory instructions pass through with 1-cycle latency and no stall.
- `branch_taken` is high for exactly the one cycle the branch sits in MEM.

## Test plan
- Reset: hold `nRST`=0 with `em_valid`=1 and `em_dREN`=1. Expect `dmemREN`=0, `wb_valid`=0, `stall_count`=0. After release, `dmemREN`=1.
- ALU op with `em_alu_out`=0x1234, dest=8, `regWEN`=1. Next cycle: `wb_wdat`=0x1234, `wb_dest_reg`=8, `wb_valid`=1, no stall.
- Load to address 0x40 with `dhit` delayed 3 cycles and `dmemload`=0xDEADBEEF:
  - `mem_stall` is high for 3 cycles and `dmemaddr`=0x40 throughout.
  - `wb_valid`=0 for 3 cycles, then `wb_wdat`=0xDEADBEEF.
  - `stall_count`=3.
- Store of 0xCAFE to 0x80 with an immediate hit: one cycle of `dmemWEN` with `dmemstore`=0xCAFE. Then `wb_regWEN`=0 and `wb_valid`=1.
- Branches:
  - BEQ with `zero`=1 and target 0x200: `branch_taken`=1 for one cycle, `branch_target`=0x200.
  - BNE with `zero`=1: `branch_taken`=0.
- JAL with `pcplusfour`=0x104 → `wb_dest_reg`=31, `wb_wdat`=0x104.
- LUI with `imm`=0xABCD → `wb_wdat`=0xABCD0000.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline latch: issues data-cache requests, stalls the
// upstream pipeline on a miss, resolves conditional branches and registers the writeback.

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

module mem_wb_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        em_valid,
  input  logic        em_dREN,
  input  logic        em_dWEN,
  input  logic        em_bEQ,
  input  logic        em_bNE,
  input  logic        em_jAL,
  input  logic        em_lUI,
  input  logic        em_regWEN,
  input  logic        em_zero,
  input  word_t       em_pcplusfour,
  input  word_t       em_rdat2,
  input  word_t       em_branch_addr,
  input  word_t       em_alu_out,
  input  regbits_t    em_dest_reg,
  input  logic [15:0] em_imm16,
  input  logic        dhit,
  input  word_t       dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output logic        mem_stall,
  output logic        branch_taken,
  output word_t       branch_target,
  output logic        wb_valid,
  output logic        wb_regWEN,
  output regbits_t    wb_dest_reg,
  output word_t       wb_wdat,
  output word_t       stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e   state_q, state_d;
  logic     memop;

  logic     wb_valid_q, wb_valid_d;
  logic     wb_regwen_q, wb_regwen_d;
  regbits_t wb_dest_q, wb_dest_d;
  word_t    wb_wdat_q, wb_wdat_d;
  word_t    stall_cnt_q, stall_cnt_d;
  word_t    wb_sel;

  assign memop = em_valid & (em_dREN | em_dWEN);

  // FSM: state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // FSM: next state. DONE is never entered; it only falls back to IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    state_d = IDLE;
    case (state_q)
      IDLE, ACCESS: state_d = (memop && !dhit) ? ACCESS : IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // FSM: outputs. Requests are masked by reset so an abandoned access stops at once.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    mem_stall = 1'b0;
    if (state_q != DONE) begin
      dmemREN   = nRST & memop & em_dREN;
      dmemWEN   = nRST & memop & em_dWEN;
      mem_stall = memop & ~dhit;
    end
  end

  assign dmemaddr      = em_alu_out;
  assign dmemstore     = em_rdat2;
  assign branch_taken  = em_valid & ((em_bEQ & em_zero) | (em_bNE & ~em_zero));
  assign branch_target = em_branch_addr;

  always_comb begin
    if (em_jAL)       wb_sel = em_pcplusfour;
    else if (em_lUI)  wb_sel = {em_imm16, 16'h0000};
    else if (em_dREN) wb_sel = dmemload;
    else              wb_sel = em_alu_out;
  end

  // A stall turns the latch into a bubble while the data fields keep their old values.
  always_comb begin
    wb_valid_d  = em_valid;
    wb_regwen_d = em_valid & em_regWEN & ~em_dWEN;
    wb_dest_d   = em_jAL ? 5'd31 : em_dest_reg;
    wb_wdat_d   = wb_sel;
    stall_cnt_d = stall_cnt_q;
    if (mem_stall) begin
      wb_valid_d  = 1'b0;
      wb_regwen_d = 1'b0;
      wb_dest_d   = wb_dest_q;
      wb_wdat_d   = wb_wdat_q;
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid_q  <= 1'b0;
      wb_regwen_q <= 1'b0;
      wb_dest_q   <= '0;
      wb_wdat_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_regwen_q <= wb_regwen_d;
      wb_dest_q   <= wb_dest_d;
      wb_wdat_q   <= wb_wdat_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_regWEN   = wb_regwen_q;
  assign wb_dest_reg = wb_dest_q;
  assign wb_wdat     = wb_wdat_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.

module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        em_valid, em_dREN, em_dWEN, em_bEQ, em_bNE, em_jAL, em_lUI, em_regWEN, em_zero;
  word_t       em_pcplusfour, em_rdat2, em_branch_addr, em_alu_out;
  regbits_t    em_dest_reg;
  logic [15:0] em_imm16;
  logic        dhit;
  word_t       dmemload;
  logic        dmemREN, dmemWEN, mem_stall, branch_taken;
  word_t       dmemaddr, dmemstore, branch_target;
  logic        wb_valid, wb_regWEN;
  regbits_t    wb_dest_reg;
  word_t       wb_wdat, stall_count;

  mem_wb_stage dut (
    .CLK(CLK), .nRST(nRST),
    .em_valid(em_valid), .em_dREN(em_dREN), .em_dWEN(em_dWEN),
    .em_bEQ(em_bEQ), .em_bNE(em_bNE), .em_jAL(em_jAL), .em_lUI(em_lUI),
    .em_regWEN(em_regWEN), .em_zero(em_zero),
    .em_pcplusfour(em_pcplusfour), .em_rdat2(em_rdat2),
    .em_branch_addr(em_branch_addr), .em_alu_out(em_alu_out),
    .em_dest_reg(em_dest_reg), .em_imm16(em_imm16),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_regWEN(wb_regWEN), .wb_dest_reg(wb_dest_reg),
    .wb_wdat(wb_wdat), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid, dren, dwen, beq, bne, jal, lui, regwen, zero;
    logic [31:0] pc4, rdat2, baddr, alu;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic        dhit;
    logic [31:0] load;
  } in_t;

  typedef struct {
    in_t         in;
    logic        e_ren, e_wen, e_stall, e_br;
    logic [31:0] e_wdat;
    logic [4:0]  e_dest;
    logic        e_valid, e_regwen;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  in_t cur;

  // Behavioural model of the MEM/WB latch contents and the stall counter.
  logic        m_valid, m_regwen;
  logic [4:0]  m_dest;
  logic [31:0] m_wdat, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t nop();
    in_t v;
    v.valid = 1'b1; v.dren = 1'b0; v.dwen = 1'b0; v.beq = 1'b0; v.bne = 1'b0;
    v.jal = 1'b0; v.lui = 1'b0; v.regwen = 1'b0; v.zero = 1'b0;
    v.pc4 = 32'h0; v.rdat2 = 32'h0; v.baddr = 32'h0; v.alu = 32'h0;
    v.dest = 5'd0; v.imm = 16'h0; v.dhit = 1'b1; v.load = 32'h0;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    int  op;
    v = nop();
    v.valid  = ($urandom_range(0, 3) != 0);
    op       = $urandom_range(0, 2);
    v.dren   = (op == 1);
    v.dwen   = (op == 2);
    v.beq    = $urandom_range(0, 1) == 1;
    v.bne    = $urandom_range(0, 1) == 1;
    v.jal    = $urandom_range(0, 5) == 0;
    v.lui    = $urandom_range(0, 5) == 0;
    v.regwen = $urandom_range(0, 1) == 1;
    v.zero   = $urandom_range(0, 1) == 1;
    v.pc4    = $urandom; v.rdat2 = $urandom; v.baddr = $urandom; v.alu = $urandom;
    v.dest   = 5'($urandom); v.imm = 16'($urandom);
    v.dhit   = $urandom_range(0, 1) == 1;
    v.load   = $urandom;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t v, input logic ren, input logic wen, input logic stall,
                               input logic br, input logic [31:0] wdat, input logic [4:0] dest,
                               input logic valid, input logic regwen);
    vec_t r;
    r.in = v; r.e_ren = ren; r.e_wen = wen; r.e_stall = stall; r.e_br = br;
    r.e_wdat = wdat; r.e_dest = dest; r.e_valid = valid; r.e_regwen = regwen;
    return r;
  endfunction

  task automatic drive(input in_t v);
    em_valid = v.valid; em_dREN = v.dren; em_dWEN = v.dwen; em_bEQ = v.beq; em_bNE = v.bne;
    em_jAL = v.jal; em_lUI = v.lui; em_regWEN = v.regwen; em_zero = v.zero;
    em_pcplusfour = v.pc4; em_rdat2 = v.rdat2; em_branch_addr = v.baddr; em_alu_out = v.alu;
    em_dest_reg = v.dest; em_imm16 = v.imm; dhit = v.dhit; dmemload = v.load;
    cur = v;
  endtask

  function automatic logic model_stall(input in_t v);
    // A real load/store that the cache has not finished yet holds the pipeline.
    return v.valid && (v.dren || v.dwen) && !v.dhit;
  endfunction

  function automatic logic [31:0] model_value(input in_t v);
    if (v.jal)  return v.pc4;
    if (v.lui)  return {v.imm, 16'h0000};
    if (v.dren) return v.load;
    return v.alu;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_regwen = 1'b0; m_dest = 5'd0; m_wdat = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic apply(input in_t v);
    drive(v);
    @(negedge CLK);
  endtask

  task automatic clock_edge();
    @(posedge CLK);
    if (!nRST) begin
      model_reset();
    end else if (model_stall(cur)) begin
      m_valid  = 1'b0;
      m_regwen = 1'b0;
      m_cnt    = m_cnt + 32'd1;
    end else begin
      m_valid  = cur.valid;
      m_regwen = cur.valid && cur.regwen && !cur.dwen;
      m_dest   = cur.jal ? 5'd31 : cur.dest;
      m_wdat   = model_value(cur);
    end
    #1;
  endtask

  task automatic check_comb_model();
    logic req;
    req = nRST && cur.valid;
    check("rand dmemREN",  dmemREN,   req && cur.dren);
    check("rand dmemWEN",  dmemWEN,   req && cur.dwen);
    check("rand dmemaddr", dmemaddr,  cur.alu);
    check("rand dmemstore", dmemstore, cur.rdat2);
    check("rand mem_stall", mem_stall, model_stall(cur));
    check("rand branch_taken", branch_taken,
          cur.valid && (cur.beq ? cur.zero : 1'b0) | (cur.valid && cur.bne && !cur.zero));
    check("rand branch_target", branch_target, cur.baddr);
  endtask

  task automatic check_regs_model();
    check("rand wb_valid",    wb_valid,    m_valid);
    check("rand wb_regWEN",   wb_regWEN,   m_regwen);
    check("rand wb_dest_reg", wb_dest_reg, m_dest);
    check("rand wb_wdat",     wb_wdat,     m_wdat);
    check("rand stall_count", stall_count, m_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    in_t  v;
    int   wen_cycles;

    // ---------------- reset behaviour ----------------
    nRST = 1'b0;
    model_reset();
    v = nop(); v.dren = 1'b1; v.dhit = 1'b0; v.alu = 32'h40;
    drive(v);
    #3;
    check("reset dmemREN forced low", dmemREN, 1'b0);
    check("reset wb_valid", wb_valid, 1'b0);
    check("reset stall_count", stall_count, 32'h0);
    check("reset wb_wdat", wb_wdat, 32'h0);
    check("reset wb_dest_reg", wb_dest_reg, 5'd0);
    check("reset mem_stall follows equation", mem_stall, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    check("reset stall_count held", stall_count, 32'h0);
    nRST = 1'b1;
    #1;
    check("post-reset dmemREN", dmemREN, 1'b1);

    // ---------------- load miss, dhit after 3 cycles ----------------
    v = nop(); v.dren = 1'b1; v.regwen = 1'b1; v.dest = 5'd12;
    v.alu = 32'h40; v.load = 32'hDEADBEEF; v.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(v);
      check("miss mem_stall", mem_stall, 1'b1);
      check("miss dmemaddr", dmemaddr, 32'h40);
      check("miss dmemREN", dmemREN, 1'b1);
      clock_edge();
      check("miss wb_valid bubble", wb_valid, 1'b0);
    end
    v.dhit = 1'b1;
    apply(v);
    check("miss hit-cycle mem_stall", mem_stall, 1'b0);
    check("miss hit-cycle dmemaddr", dmemaddr, 32'h40);
    clock_edge();
    check("miss wb_valid", wb_valid, 1'b1);
    check("miss wb_wdat", wb_wdat, 32'hDEADBEEF);
    check("miss stall_count", stall_count, 32'd3);

    // ---------------- directed vector table ----------------
    v = nop(); v.alu = 32'h1234; v.dest = 5'd8; v.regwen = 1'b1;
    vecs[0] = mkv(v, 0, 0, 0, 0, 32'h1234, 5'd8, 1, 1);
    v = nop(); v.dwen = 1'b1; v.alu = 32'h80; v.rdat2 = 32'hCAFE; v.regwen = 1'b1; v.dest = 5'd3;
    vecs[1] = mkv(v, 0, 1, 0, 0, 32'h80, 5'd3, 1, 0);
    v = nop(); v.beq = 1'b1; v.zero = 1'b1; v.baddr = 32'h200; v.alu = 32'h5;
    vecs[2] = mkv(v, 0, 0, 0, 1, 32'h5, 5'd0, 1, 0);
    v = nop(); v.bne = 1'b1; v.zero = 1'b1; v.baddr = 32'h300; v.alu = 32'h6;
    vecs[3] = mkv(v, 0, 0, 0, 0, 32'h6, 5'd0, 1, 0);
    v = nop(); v.bne = 1'b1; v.zero = 1'b0; v.baddr = 32'h340; v.alu = 32'h7;
    vecs[4] = mkv(v, 0, 0, 0, 1, 32'h7, 5'd0, 1, 0);
    v = nop(); v.jal = 1'b1; v.pc4 = 32'h104; v.dest = 5'd5; v.regwen = 1'b1; v.alu = 32'h77;
    vecs[5] = mkv(v, 0, 0, 0, 0, 32'h104, 5'd31, 1, 1);
    v = nop(); v.lui = 1'b1; v.imm = 16'hABCD; v.dest = 5'd9; v.regwen = 1'b1; v.alu = 32'h1;
    vecs[6] = mkv(v, 0, 0, 0, 0, 32'hABCD0000, 5'd9, 1, 1);
    v = nop(); v.dren = 1'b1; v.alu = 32'h44; v.load = 32'h11223344; v.dest = 5'd10; v.regwen = 1'b1;
    vecs[7] = mkv(v, 1, 0, 0, 0, 32'h11223344, 5'd10, 1, 1);
    v = nop(); v.jal = 1'b1; v.lui = 1'b1; v.pc4 = 32'h208; v.imm = 16'h1111; v.dest = 5'd2; v.regwen = 1'b1;
    vecs[8] = mkv(v, 0, 0, 0, 0, 32'h208, 5'd31, 1, 1);
    v = nop(); v.valid = 1'b0; v.dren = 1'b1; v.dhit = 1'b0; v.regwen = 1'b1; v.beq = 1'b1;
    v.zero = 1'b1; v.load = 32'h55; v.dest = 5'd4;
    vecs[9] = mkv(v, 0, 0, 0, 0, 32'h55, 5'd4, 0, 0);
    v = nop(); v.lui = 1'b1; v.dren = 1'b1; v.imm = 16'h00F0; v.load = 32'h99; v.dest = 5'd6; v.regwen = 1'b1;
    vecs[10] = mkv(v, 1, 0, 0, 0, 32'h00F00000, 5'd6, 1, 1);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].in);
      check($sformatf("vec%0d dmemREN", i), dmemREN, vecs[i].e_ren);
      check($sformatf("vec%0d dmemWEN", i), dmemWEN, vecs[i].e_wen);
      check($sformatf("vec%0d mem_stall", i), mem_stall, vecs[i].e_stall);
      check($sformatf("vec%0d branch_taken", i), branch_taken, vecs[i].e_br);
      check($sformatf("vec%0d branch_target", i), branch_target, vecs[i].in.baddr);
      if (vecs[i].e_wen) begin
        check($sformatf("vec%0d dmemstore", i), dmemstore, vecs[i].in.rdat2);
        check($sformatf("vec%0d dmemaddr", i), dmemaddr, vecs[i].in.alu);
      end
      clock_edge();
      check($sformatf("vec%0d wb_wdat", i), wb_wdat, vecs[i].e_wdat);
      check($sformatf("vec%0d wb_dest_reg", i), wb_dest_reg, vecs[i].e_dest);
      check($sformatf("vec%0d wb_valid", i), wb_valid, vecs[i].e_valid);
      check($sformatf("vec%0d wb_regWEN", i), wb_regWEN, vecs[i].e_regwen);
      if (i == 2) begin
        apply(nop());
        check("beq branch_taken one cycle", branch_taken, 1'b0);
        clock_edge();
      end
    end
    check("table stall_count unchanged", stall_count, 32'd3);

    // ---------------- store window: miss twice then hit ----------------
    wen_cycles = 0;
    v = nop(); v.dwen = 1'b1; v.alu = 32'h88; v.rdat2 = 32'h1357; v.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v.dhit = (i == 2);
      apply(v);
      if (dmemWEN) wen_cycles++;
      check("store window dmemstore", dmemstore, 32'h1357);
      clock_edge();
    end
    check("store window length", wen_cycles, 3);
    apply(nop());
    check("store not reissued", dmemWEN, 1'b0);
    clock_edge();
    check("store window stall_count", stall_count, 32'd5);

    // ---------------- flush during ACCESS ----------------
    v = nop(); v.dren = 1'b1; v.dhit = 1'b0; v.alu = 32'h90;
    apply(v);
    clock_edge();
    v.valid = 1'b0;
    apply(v);
    check("flush drops dmemREN", dmemREN, 1'b0);
    check("flush drops mem_stall", mem_stall, 1'b0);
    clock_edge();
    check("flush wb_valid", wb_valid, 1'b0);
    check("flush stall_count", stall_count, 32'd6);

    // ---------------- reset during ACCESS ----------------
    v = nop(); v.dwen = 1'b1; v.dhit = 1'b0; v.alu = 32'hA0; v.rdat2 = 32'h2468;
    apply(v);
    clock_edge();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check("reset-in-access dmemWEN", dmemWEN, 1'b0);
    check("reset-in-access stall_count", stall_count, 32'h0);
    check("reset-in-access wb_valid", wb_valid, 1'b0);
    v.valid = 1'b0;
    drive(v);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    check("post-reset no store", dmemWEN, 1'b0);

    // ---------------- randomized traffic vs model ----------------
    v = rand_in();
    for (int i = 0; i < 400; i++) begin
      if (model_stall(cur) && $urandom_range(0, 9) != 0) begin
        v = cur;
        v.dhit = $urandom_range(0, 2) == 0;
        v.load = $urandom;
      end else begin
        v = rand_in();
      end
      apply(v);
      check_comb_model();
      clock_edge();
      check_regs_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
